// File: rtl/spi_rom_read_arbiter.sv
// spi_rom_read_arbiter
//   Shares one SPI flash ROM between two read requesters. A granted read
//   sends READ_CMD plus a 24-bit address MSB first, then clocks in
//   DATA_BYTES bytes and hands each one back to the winner.
//   SPI mode 0 with SCLK = clk/2. CS is active HIGH, matching the board.
//
// Ports
//   clk, reset_n        system clock; asynchronous active-low reset
//   req0/addr0          requester 0: level request and byte address
//   req1/addr1          requester 1: level request and byte address
//   ack                 1-cycle pulse when a request is accepted
//   busy                high from ack until the FSM is back in IDLE
//   rd_valid/rd_data    1-cycle pulse with one received byte
//   rd_id               owner of the current transfer
//   done                1-cycle pulse together with the final rd_valid
//   spi_cs/sclk/mosi    ROM pins (outputs); spi_miso is the ROM data input
module spi_rom_read_arbiter #(
  parameter int         DATA_BYTES = 16,
  parameter int         GAP_CYCLES = 2,
  parameter logic [7:0] READ_CMD   = 8'h03,
  parameter bit         ARB_RR     = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [23:0] addr0,
  input  logic        req1,
  input  logic [23:0] addr1,
  output logic        ack,
  output logic        busy,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_id,
  output logic        done,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int NBITS = 32 + 8 * DATA_BYTES;
  localparam int CW    = $clog2(NBITS);
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] LAST_BIT   = CW'(NBITS - 1);
  localparam logic [CW-1:0] FIRST_DATA = CW'(32);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  typedef struct packed {
    logic        id;
    logic [23:0] addr;
  } req_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic          phase;     // 0: sclk low, mosi settling; 1: sclk high
  logic [30:0]   tx_sr;     // command/address bits still to go out after the current mosi bit
  logic [6:0]    rx_sr;     // first seven bits of the byte being received
  logic [GW-1:0] gap_cnt;
  logic          last_id;   // id granted most recently (round-robin pointer)

  logic grant;
  req_t win;

  // Arbitration: only one requester -> it wins. Both -> req0 under fixed
  // priority, or the one not granted last under round-robin.
  always_comb begin
    grant = req0 | req1;
    win.id = req1 & ~req0;
    if (req0 && req1 && ARB_RR) win.id = ~last_id;
    win.addr = win.id ? addr1 : addr0;
  end

  // The last bit of every data byte falls on bit_cnt[2:0] == 7, because the
  // 32-bit command/address header is byte aligned.
  logic byte_end;
  assign byte_end = (bit_cnt >= FIRST_DATA) && (bit_cnt[2:0] == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      gap_cnt  <= '0;
      last_id  <= 1'b1;   // so that req0 wins the first tie
      ack      <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_id    <= 1'b0;
      done     <= 1'b0;
      spi_cs   <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      ack      <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= SHIFT;
            ack      <= 1'b1;
            busy     <= 1'b1;
            rd_id    <= win.id;
            last_id  <= win.id;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= READ_CMD[7];
            tx_sr    <= {READ_CMD[6:0], win.addr};
            bit_cnt  <= '0;
            phase    <= 1'b0;
          end
        end
        SHIFT: begin
          if (!phase) begin
            spi_sclk <= 1'b1;
            phase    <= 1'b1;
          end else begin
            // End of sclk-high phase: sample MISO, drop sclk and move MOSI
            // on to the next bit. Once the header has gone out, the shift
            // register holds only zeros, so MOSI stays low for data bits.
            spi_sclk <= 1'b0;
            phase    <= 1'b0;
            rx_sr    <= {rx_sr[5:0], spi_miso};
            spi_mosi <= tx_sr[30];
            tx_sr    <= {tx_sr[29:0], 1'b0};
            if (byte_end) begin
              rd_valid <= 1'b1;
              rd_data  <= {rx_sr, spi_miso};
            end
            if (bit_cnt == LAST_BIT) begin
              done     <= 1'b1;
              spi_cs   <= 1'b0;
              spi_mosi <= 1'b0;
              gap_cnt  <= GAP_LOAD;
              state    <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_read_arbiter.sv
// Directed bench for spi_rom_read_arbiter.
//   Instance 0 uses the default parameters: 16 bytes and fixed priority.
//   Instance 1 uses DATA_BYTES=1 with round-robin arbitration.
//   The ROM model returns byte k = k+1. Cycle labels count from the clock
//   edge at which IDLE samples the request (T); "T+n" is the value visible
//   just before edge T+n.
module tb_spi_rom_read_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        req0[2], req1[2];
  logic [23:0] addr0[2], addr1[2];
  logic        ack[2], busy[2], rd_valid[2], rd_id[2], done[2];
  logic        cs[2], sclk[2], mosi[2];
  logic [7:0]  rd_data[2];
  bit          miso[2];

  spi_rom_read_arbiter u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0[0]), .addr0(addr0[0]), .req1(req1[0]), .addr1(addr1[0]),
    .ack(ack[0]), .busy(busy[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .rd_id(rd_id[0]), .done(done[0]),
    .spi_cs(cs[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_rom_read_arbiter #(.DATA_BYTES(1), .ARB_RR(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0[1]), .addr0(addr0[1]), .req1(req1[1]), .addr1(addr1[1]),
    .ack(ack[1]), .busy(busy[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .rd_id(rd_id[1]), .done(done[1]),
    .spi_cs(cs[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ROM model: byte k of a transfer is k+1, MSB first after the 32 header bits.
  function automatic bit rom_bit(input int k);
    logic [7:0] b;
    if (k < 32) return 1'b0;
    b = 8'((k - 32) / 8 + 1);
    return b[7 - ((k - 32) % 8)];
  endfunction

  // Pin monitor, evaluated mid-cycle (negedge) for both instances.
  int          sc[2], csh[2], nb[2], done_cnt[2], ack_cnt[2], mosi_err[2], sclk_err[2];
  logic [31:0] mosi_w[2];
  logic [7:0]  data[2][16];
  int          vlbl[2][16];
  bit          psclk[2], pcs[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs[i] === 1'b1 && !pcs[i]) begin
        sc[i] = 0; csh[i] = 0; nb[i] = 0; mosi_w[i] = '0;
      end
      if (cs[i] === 1'b1) csh[i]++;
      if (sclk[i] === 1'b1 && cs[i] !== 1'b1) sclk_err[i]++;
      if (sclk[i] === 1'b1 && !psclk[i]) begin
        if (sc[i] < 32) mosi_w[i] = {mosi_w[i][30:0], mosi[i]};
        else if (mosi[i] !== 1'b0) mosi_err[i]++;
        miso[i] = rom_bit(sc[i]);
        sc[i]++;
      end
      if (ack[i] === 1'b1) ack_cnt[i]++;
      if (rd_valid[i] === 1'b1) begin
        if (nb[i] < 16) begin
          data[i][nb[i]] = rd_data[i];
          vlbl[i][nb[i]] = cyc + 1;
        end
        nb[i]++;
      end
      if (done[i] === 1'b1) done_cnt[i]++;
      psclk[i] = (sclk[i] === 1'b1);
      pcs[i]   = (cs[i] === 1'b1);
    end
  end

  task automatic wait_ack(input int i, input int limit, output int lbl, output bit ok);
    ok = 1'b0; lbl = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (ack[i] === 1'b1) begin ok = 1'b1; lbl = cyc + 1; return; end
    end
  endtask

  task automatic wait_done(input int i, input int limit, output int lbl, output bit ok);
    ok = 1'b0; lbl = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done[i] === 1'b1) begin ok = 1'b1; lbl = cyc + 1; return; end
    end
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (busy[i] === 1'b0) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", 32'(ok), 1);
  endtask

  initial begin
    int  t0, lbl, prev, base;
    bit  ok;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; addr0[i] = '0; addr1[i] = '0;
    end

    // Reset state
    #1;
    chk("rst_cs",    32'(cs[0]), 0);
    chk("rst_sclk",  32'(sclk[0]), 0);
    chk("rst_mosi",  32'(mosi[0]), 0);
    chk("rst_busy",  32'(busy[0]), 0);
    chk("rst_ack",   32'(ack[0]), 0);
    chk("rst_valid", 32'(rd_valid[0]), 0);
    chk("rst_done",  32'(done[0]), 0);
    chk("rst_data",  32'(rd_data[0]), 0);
    chk("rst_busy1", 32'(busy[1]), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read by requester 0
    req0[0] = 1'b1; addr0[0] = 24'h000120; t0 = cyc + 1;
    wait_ack(0, 5, lbl, ok);
    chk("t2_ack_seen", 32'(ok), 1);
    chk("t2_ack_time", lbl - t0, 1);
    chk("t2_ack_id",   32'(rd_id[0]), 0);
    chk("t2_busy",     32'(busy[0]), 1);
    chk("t2_cs",       32'(cs[0]), 1);
    chk("t2_sclk",     32'(sclk[0]), 0);
    chk("t2_mosi0",    32'(mosi[0]), 0);
    req0[0] = 1'b0;
    wait_done(0, 400, lbl, ok);
    chk("t2_done_seen", 32'(ok), 1);
    chk("t2_done_time", lbl - t0, 321);
    chk("t2_done_id",   32'(rd_id[0]), 0);
    chk("t2_done_valid", 32'(rd_valid[0]), 1);
    chk("t2_done_cs",   32'(cs[0]), 0);
    @(negedge clk);
    chk("t2_mosi_hdr", mosi_w[0], 32'h03000120);
    chk("t2_nbytes",   nb[0], 16);
    for (int k = 0; k < 16; k++) begin
      chk("t2_byte",      32'(data[0][k]), k + 1);
      chk("t2_byte_time", vlbl[0][k] - t0, 81 + 16 * k);
    end
    chk("t2_cs_cycles",   csh[0], 320);
    chk("t2_sclk_pulses", sc[0], 160);
    chk("t2_mosi_data0",  mosi_err[0], 0);
    chk("t2_gap_busy",    32'(busy[0]), 1);
    @(negedge clk);
    chk("t2_idle_busy",   32'(busy[0]), 0);

    // Both requesters at once, fixed priority
    @(negedge clk);
    req0[0] = 1'b1; req1[0] = 1'b1; addr0[0] = 24'h000200; addr1[0] = 24'h000300;
    t0 = cyc + 1;
    wait_ack(0, 5, lbl, ok);
    chk("t3_ack0_seen", 32'(ok), 1);
    chk("t3_ack0_time", lbl - t0, 1);
    chk("t3_ack0_id",   32'(rd_id[0]), 0);
    req0[0] = 1'b0;
    wait_ack(0, 400, lbl, ok);
    chk("t3_ack1_seen", 32'(ok), 1);
    chk("t3_ack1_time", lbl - t0, 324);
    chk("t3_ack1_id",   32'(rd_id[0]), 1);
    req1[0] = 1'b0;
    wait_done(0, 400, lbl, ok);
    chk("t3_done_seen", 32'(ok), 1);
    chk("t3_done_id",   32'(rd_id[0]), 1);
    @(negedge clk);
    chk("t3_mosi_hdr", mosi_w[0], 32'h03000300);
    chk("t3_nbytes",   nb[0], 16);
    wait_idle(0);

    // req1 dropped right after ack; req0 pulsed for one cycle while busy
    base = ack_cnt[0];
    @(negedge clk);
    req1[0] = 1'b1; addr1[0] = 24'h00ABCD;
    wait_ack(0, 5, lbl, ok);
    chk("t5_ack_seen", 32'(ok), 1);
    chk("t5_ack_id",   32'(rd_id[0]), 1);
    req1[0] = 1'b0;
    repeat (10) @(negedge clk);
    req0[0] = 1'b1; addr0[0] = 24'h000555;
    @(negedge clk);
    req0[0] = 1'b0;
    wait_done(0, 400, lbl, ok);
    chk("t5_done_seen", 32'(ok), 1);
    chk("t5_done_id",   32'(rd_id[0]), 1);
    @(negedge clk);
    chk("t5_nbytes",   nb[0], 16);
    chk("t5_last",     32'(data[0][15]), 32'h10);
    chk("t5_mosi_hdr", mosi_w[0], 32'h0300ABCD);
    repeat (20) @(negedge clk);
    chk("t5_ack_count", ack_cnt[0] - base, 1);
    chk("t5_idle",      32'(busy[0]), 0);

    // Round-robin with both held, one-byte reads at the top of the address space
    req0[1] = 1'b1; req1[1] = 1'b1; addr0[1] = 24'hFFFFFF; addr1[1] = 24'hFFFFFF;
    prev = -1;
    for (int n = 0; n < 4; n++) begin
      wait_ack(1, 200, lbl, ok);
      chk("t4_ack_seen", 32'(ok), 1);
      chk("t4_grant_id", 32'(rd_id[1]), n % 2);
      if (n > 0) chk("t4_ack_spacing", lbl - prev, 83);
      prev = lbl;
    end
    req0[1] = 1'b0; req1[1] = 1'b0;
    t0 = prev - 1;
    wait_done(1, 200, lbl, ok);
    chk("t6_done_seen",  32'(ok), 1);
    chk("t6_done_time",  lbl - t0, 81);
    chk("t6_done_valid", 32'(rd_valid[1]), 1);
    chk("t6_done_id",    32'(rd_id[1]), 1);
    @(negedge clk);
    chk("t6_nbytes",      nb[1], 1);
    chk("t6_byte",        32'(data[1][0]), 1);
    chk("t6_byte_time",   vlbl[1][0] - t0, 81);
    chk("t6_cs_cycles",   csh[1], 80);
    chk("t6_sclk_pulses", sc[1], 40);
    chk("t6_mosi_hdr",    mosi_w[1], 32'h03FFFFFF);
    chk("t6_mosi_data0",  mosi_err[1], 0);

    // Reset in the middle of a transfer
    wait_idle(0);
    base = done_cnt[0];
    @(negedge clk);
    req0[0] = 1'b1; addr0[0] = 24'hFFFFFF;
    wait_ack(0, 5, lbl, ok);
    chk("t1_ack_seen", 32'(ok), 1);
    req0[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("t1_cs_before", 32'(cs[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_cs",    32'(cs[0]), 0);
    chk("t1_sclk",  32'(sclk[0]), 0);
    chk("t1_mosi",  32'(mosi[0]), 0);
    chk("t1_ack",   32'(ack[0]), 0);
    chk("t1_busy",  32'(busy[0]), 0);
    chk("t1_valid", 32'(rd_valid[0]), 0);
    chk("t1_done",  32'(done[0]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("t1_no_done",  done_cnt[0] - base, 0);
    chk("t1_idle",     32'(busy[0]), 0);
    chk("t1_cs_idle",  32'(cs[0]), 0);
    chk("sclk_no_cs0", sclk_err[0], 0);
    chk("sclk_no_cs1", sclk_err[1], 0);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
